// File: rtl/sprite_anim_ctrl.sv
// Death-animation sequencer for a 32x32 sprite: steps through up to four frame RAMs
// on vsync-rate ticks and produces a key-coloured pixel stream aligned with the RAM read.
module sprite_anim_ctrl #(
    parameter int          FRAMES_PER_STEP = 8,
    parameter int          NUM_FRAMES      = 3,
    parameter logic [23:0] KEY_COLOR       = 24'hfffed2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        clear,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [23:0] ram_data0,
    input  logic [23:0] ram_data1,
    input  logic [23:0] ram_data2,
    input  logic [23:0] ram_data3,
    output logic [18:0] read_address,
    output logic [23:0] rgb_out,
    output logic        pixel_valid,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         frame_idx;
    logic [CNT_W-1:0]   tick_cnt;
    logic               frame_clk_q;
    logic               tick;

    logic [9:0]         dx;
    logic [9:0]         dy;
    logic               in_win;
    logic               in_win_d;
    logic               active_d;
    logic [1:0]         sel_d;

    assign tick = frame_clk & ~frame_clk_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            frame_clk_q <= frame_clk;
        end
    end

    // busy/done are updated alongside each transition so they decode the registered state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            frame_idx <= 2'd0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            frame_idx <= 2'd0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= PLAY;
                        frame_idx <= 2'd0;
                        tick_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (tick_cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
                            tick_cnt <= '0;
                            if (frame_idx < 2'(NUM_FRAMES - 1)) begin
                                frame_idx <= frame_idx + 2'd1;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Negative offsets wrap to large unsigned values and fall outside the window.
    assign dx     = DrawX - sprite_x;
    assign dy     = DrawY - sprite_y;
    assign in_win = (dx[9:5] == 5'd0) && (dy[9:5] == 5'd0);

    assign read_address = in_win ? {9'b0, dy[4:0], dx[4:0]} : 19'd0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_win_d <= 1'b0;
            active_d <= 1'b0;
            sel_d    <= 2'd0;
        end else begin
            in_win_d <= in_win;
            active_d <= (state != IDLE);
            sel_d    <= frame_idx;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves rgb_out unassigned (no latch).
        rgb_out = ram_data0;
        case (sel_d)
            2'd1:    rgb_out = ram_data1;
            2'd2:    rgb_out = ram_data2;
            2'd3:    rgb_out = ram_data3;
            default: rgb_out = ram_data0;
        endcase
    end

    assign pixel_valid = in_win_d & active_d & (rgb_out != KEY_COLOR);

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl: frame sequencing, addressing, keying, priority and reset.
module tb_sprite_anim_ctrl;

    localparam logic [23:0] C0  = 24'h100000;
    localparam logic [23:0] C1  = 24'h211111;
    localparam logic [23:0] C2  = 24'h322222;
    localparam logic [23:0] C3  = 24'h433333;
    localparam logic [23:0] KEY = 24'hfffed2;

    logic        Clk;
    logic        Reset_n;
    logic        frame_clk;
    logic        start;
    logic        clear;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [23:0] ram_data0;
    logic [23:0] ram_data1;
    logic [23:0] ram_data2;
    logic [23:0] ram_data3;
    logic [18:0] read_address;
    logic [23:0] rgb_out;
    logic        pixel_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    sprite_anim_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .start        (start),
        .clear        (clear),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .ram_data0    (ram_data0),
        .ram_data1    (ram_data1),
        .ram_data2    (ram_data2),
        .ram_data3    (ram_data3),
        .read_address (read_address),
        .rgb_out      (rgb_out),
        .pixel_valid  (pixel_valid),
        .busy         (busy),
        .done         (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    function automatic logic [23:0] color_of(input int idx);
        case (idx)
            0:       return C0;
            1:       return C1;
            2:       return C2;
            default: return C3;
        endcase
    endfunction

    task automatic test_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        sprite_x  = 10'd100;
        sprite_y  = 10'd50;
        DrawX     = 10'd103;
        DrawY     = 10'd52;
        ram_data0 = C0;
        ram_data1 = C1;
        ram_data2 = C2;
        ram_data3 = C3;
        #2;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b pixel_valid=%b, wanted 0 0 0",
                     busy, done, pixel_valid);
        end
        total++;
        if (rgb_out !== C0) begin
            bad++;
            $display("FAIL reset_rgb: got %h want %h", rgb_out, C0);
        end
        step();
        step();
        Reset_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b done=%b, wanted 0 0", busy, done);
        end
    endtask

    task automatic test_addressing();
        DrawX = 10'd103;
        DrawY = 10'd52;
        #1;
        total++;
        if (read_address !== 19'd67) begin
            bad++;
            $display("FAIL addr_inside: got %0d want 67", read_address);
        end
        step();
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_not_drawn: pixel_valid=%b want 0", pixel_valid);
        end
        DrawX = 10'd131;
        DrawY = 10'd81;
        #1;
        total++;
        if (read_address !== 19'd1023) begin
            bad++;
            $display("FAIL addr_corner: got %0d want 1023", read_address);
        end
        DrawX = 10'd99;
        DrawY = 10'd52;
        #1;
        total++;
        if (read_address !== 19'd0) begin
            bad++;
            $display("FAIL addr_left_of_win: got %0d want 0", read_address);
        end
        DrawX = 10'd132;
        #1;
        total++;
        if (read_address !== 19'd0) begin
            bad++;
            $display("FAIL addr_right_of_win: got %0d want 0", read_address);
        end
        DrawX = 10'd103;
        DrawY = 10'd82;
        #1;
        total++;
        if (read_address !== 19'd0) begin
            bad++;
            $display("FAIL addr_below_win: got %0d want 0", read_address);
        end
        DrawY = 10'd52;
    endtask

    task automatic test_play_sequence();
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL play_entry: busy=%b done=%b, wanted 1 0", busy, done);
        end
        step();
        total++;
        if (rgb_out !== C0 || pixel_valid !== 1'b1) begin
            bad++;
            $display("FAIL play_first_pixel: rgb=%h valid=%b, wanted %h 1", rgb_out, pixel_valid, C0);
        end
        ram_data0 = 24'h350202;
        step();
        total++;
        if (rgb_out !== 24'h350202 || pixel_valid !== 1'b1) begin
            bad++;
            $display("FAIL color_pixel: rgb=%h valid=%b, wanted 350202 1", rgb_out, pixel_valid);
        end
        ram_data0 = KEY;
        step();
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL key_color: valid=%b want 0", pixel_valid);
        end
        ram_data0 = C0;
        DrawX = 10'd99;
        step();
        total++;
        if (pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL out_of_win_valid: valid=%b want 0", pixel_valid);
        end
        DrawX = 10'd103;
        for (int t = 1; t <= 24; t++) begin
            frame_tick();
            total++;
            if (t < 24) begin
                if (busy !== 1'b1 || done !== 1'b0 || rgb_out !== color_of(t / 8)) begin
                    bad++;
                    $display("FAIL play_tick_%0d: busy=%b done=%b rgb=%h, wanted 1 0 %h",
                             t, busy, done, rgb_out, color_of(t / 8));
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || rgb_out !== C2 || pixel_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL play_done: busy=%b done=%b rgb=%h valid=%b, wanted 0 1 %h 1",
                             busy, done, rgb_out, pixel_valid, C2);
                end
            end
        end
        frame_tick();
        frame_tick();
        total++;
        if (done !== 1'b1 || rgb_out !== C2) begin
            bad++;
            $display("FAIL done_hold: done=%b rgb=%h, wanted 1 %h", done, rgb_out, C2);
        end
    endtask

    task automatic test_priority();
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_over_start: busy=%b done=%b, wanted 0 0", busy, done);
        end
        step();
        total++;
        if (pixel_valid !== 1'b0 || rgb_out !== C0) begin
            bad++;
            $display("FAIL clear_blank: valid=%b rgb=%h, wanted 0 %h", pixel_valid, rgb_out, C0);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 7; t++) frame_tick();
        start = 1'b1;
        step();
        start = 1'b0;
        frame_tick();
        total++;
        if (busy !== 1'b1 || rgb_out !== C1) begin
            bad++;
            $display("FAIL start_in_play: busy=%b rgb=%h, wanted 1 %h", busy, rgb_out, C1);
        end
    endtask

    task automatic test_clear_with_tick();
        frame_clk = 1'b1;
        clear     = 1'b1;
        step();
        frame_clk = 1'b0;
        clear     = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL clear_over_tick: busy=%b done=%b, wanted 0 0", busy, done);
        end
        step();
        total++;
        if (rgb_out !== C0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_tick_blank: rgb=%h valid=%b, wanted %h 0", rgb_out, pixel_valid, C0);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 9; t++) frame_tick();
        total++;
        if (busy !== 1'b1 || rgb_out !== C1 || pixel_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_frame1: busy=%b rgb=%h valid=%b, wanted 1 %h 1",
                     busy, rgb_out, pixel_valid, C1);
        end
        #1;
        Reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0 || rgb_out !== C0) begin
            bad++;
            $display("FAIL async_reset: busy=%b valid=%b rgb=%h, wanted 0 0 %h",
                     busy, pixel_valid, rgb_out, C0);
        end
        frame_clk = 1'b1;
        step();
        Reset_n = 1'b1;
        step();
        frame_clk = 1'b0;
        for (int t = 0; t < 3; t++) frame_tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b done=%b valid=%b, wanted 0 0 0",
                     busy, done, pixel_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++;
        if (busy !== 1'b1 || rgb_out !== C0 || pixel_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_after_reset: busy=%b rgb=%h valid=%b, wanted 1 %h 1",
                     busy, rgb_out, pixel_valid, C0);
        end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_play_sequence();
        test_priority();
        test_start_ignored();
        test_clear_with_tick();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
